mac_result_collector: RTL and testbench
=======================================

// Module: mac_result_collector
// PURPOSE
//   Receiver end of the MAC engine valid/ready result handshake. Drives the engine's
//   ready input and captures the 20-bit sum on each accepted handshake. Sign-/zero-
//   extends the sum and tags it with a sequence number, then queues it in a small
//   FIFO. Presents queued results to a downstream consumer over a second valid/ready port.
// PARAMETERS
//   SUM_W   20  width of engine sum input
//   OUT_W   32  width of extended result word (OUT_W >= SUM_W)
//   DEPTH   4   FIFO entries (power of two, >= 2)
//   TAG_W   8   sequence-tag width
// PORTS
//   clk        in   1       clock, rising edge
//   nrst       in   1       reset, synchronous, active-low
//   en         in   1       collector enable (high while the engine runs batches)
//   signed_res in   1       1: sign-extend sum (sx|sy of the run); 0: zero-extend
//   mac_valid  in   1       engine result valid
//   mac_sum    in   SUM_W   engine sum; sampled only on handshake edge
//   mac_ready  out  1       ready to engine
//   out_valid  out  1       downstream result valid
//   out_data   out  OUT_W   extended result at FIFO head
//   out_tag    out  TAG_W   sequence tag at FIFO head
//   out_ready  in   1       downstream ready
//   level      out  log2(DEPTH)+1  entries held
//   busy       out  1       state != S_IDLE
// BEHAVIOUR
//   Reset (nrst=0 at edge): state=S_IDLE, wr/rd ptrs=0, level=0, seq=0.
//     mac_ready=0, out_valid=0, out_data/out_tag=0 (mem cleared), busy=0.
//     Reset mid-operation discards all queued results; the engine must be reset alongside.
//   FSM
//     S_IDLE -> S_RECV when en=1.
//     S_RECV -> S_DRAIN when en=0.
//     S_DRAIN -> S_RECV if en=1 again; -> S_IDLE when level==0.
//   mac_ready = (state==S_RECV) && (level<DEPTH). Combinational from registers only,
//     never from mac_valid.
//   Push: mac_valid && mac_ready at a rising edge. Store {ext(mac_sum), seq} at wr_ptr,
//     then wr_ptr++ and seq++. Zero-latency capture: the sum is taken on the same edge
//     the engine samples ready, because the engine's sum is a live wire.
//   ext(): signed_res ? sign-extend mac_sum[SUM_W-1] : zero-extend, to OUT_W.
//   seq wraps (2^TAG_W-1) -> 0; it resets only on nrst, not on en.
//   Pop (first-word-fall-through):
//     out_valid = (level!=0); out_data/out_tag = mem[rd_ptr].
//     out_valid && out_ready at an edge -> rd_ptr++.
//   Simultaneous push+pop: level unchanged, both ptrs advance.
//   Full (level==DEPTH): mac_ready=0 even if a pop occurs the same cycle, so one
//     bubble is accepted. The engine holds valid/sum, so no result is lost.
//   Empty: out_valid=0, and out_ready is ignored. Pointers wrap mod DEPTH.
//   out_valid, once high, stays high with stable data until popped (AXI-style rule).
//   Latency: mac handshake edge -> out_valid high next cycle (1 cycle) if FIFO was empty.
//   Mode/precision changes are transparent; the sum is treated as an opaque SUM_W word.
// STRUCTURE
//   Shared package mac_pkg: SUM_W/OUT_W defaults, mode localparams (2bx2b=0,
//     4bx4b=1, 8bx8b=2), collector state encodings (S_IDLE=0, S_RECV=1, S_DRAIN=2).
//   Sub-module result_fifo (sync FWFT FIFO, WIDTH=OUT_W+TAG_W, DEPTH): push/pop/
//     level/full/empty. The top holds the FSM, ready logic, extension and sequence counter.
// TESTING
//   1 Reset: nrst=0 for 2 cycles with mac_valid=1 -> mac_ready=0, out_valid=0, level=0.
//   2 Single result: en=1, mac_sum=20'hFFFFE, signed_res=1, handshake ->
//     next cycle out_valid=1, out_data=32'hFFFFFFFE, out_tag=0. With signed_res=0
//     the same sum -> out_data=32'h000FFFFE.
//   3 Fill: out_ready=0, push 4 results (sums 1..4) -> level=4, mac_ready=0.
//     Engine holds sum 5. Set out_ready=1 -> pop order 1,2,3,4,5, tags 0..4, no loss.
//   4 Simultaneous: level=2, push and pop on the same edge -> level stays 2,
//     head advances to the next tag.
//   5 Drain: level=3, drop en -> busy=1, mac_ready=0. After 3 pops, S_IDLE,
//     busy=0 next cycle.
//   6 Wrap + mid-reset: 260 pushes -> tag wraps 255->0. Assert nrst mid-queue ->
//     level=0, seq restarts at 0.

Source files
------------

// File: rtl/mac_result_collector_pkg.sv
// Shared definitions for the MAC result collector: default widths, MAC mode codes
// and the collector state encoding.
package mac_result_collector_pkg;

    localparam int SUM_W_DEF = 20;
    localparam int OUT_W_DEF = 32;
    localparam int DEPTH_DEF = 4;
    localparam int TAG_W_DEF = 8;

    localparam logic [1:0] MODE_2X2 = 2'd0;
    localparam logic [1:0] MODE_4X4 = 2'd1;
    localparam logic [1:0] MODE_8X8 = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_DRAIN = 2'd2
    } coll_state_t;

endpackage

// File: rtl/mac_result_collector_if.sv
// Engine-side result handshake and downstream result port of the collector.
// The collector uses the slave view; the engine/consumer side uses master.
interface mac_result_collector_if
    import mac_result_collector_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int TAG_W = TAG_W_DEF
);
    logic             mac_valid;
    logic [SUM_W-1:0] mac_sum;
    logic             mac_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_ready;

    modport slave (
        input  mac_valid, mac_sum, out_ready,
        output mac_ready, out_valid, out_data, out_tag
    );

    modport master (
        output mac_valid, mac_sum, out_ready,
        input  mac_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/mac_result_collector_result_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata always shows the head entry.
// Storage is cleared on reset so an empty FIFO presents zeros.
module result_fifo
    import mac_result_collector_pkg::*;
#(
    parameter int WIDTH = OUT_W_DEF + TAG_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign level   = cnt;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            // Push and pop together leave the count unchanged.
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mac_result_collector.sv
// Receives MAC engine sums over valid/ready, extends and tags them, and queues
// them in an FWFT FIFO for a downstream valid/ready consumer.
module mac_result_collector
    import mac_result_collector_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   en,
    input  logic                   signed_res,
    mac_result_collector_if.slave  bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy
);
    coll_state_t            state;
    coll_state_t            state_nxt;
    logic [TAG_W-1:0]       seq;
    logic                   mac_ready_c;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [OUT_W+TAG_W-1:0] head;

    function automatic logic [OUT_W-1:0] extend(input logic [SUM_W-1:0] sum, input logic sgn);
        logic signed [SUM_W-1:0] s_sum;
        logic [OUT_W-1:0]        r;
        s_sum = $signed(sum);
        r     = sgn ? OUT_W'(s_sum) : OUT_W'(sum);
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!nrst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (en) state_nxt = S_RECV;
            S_RECV:  if (!en) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (en)         state_nxt = S_RECV;
                else if (empty) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Ready depends on registered state only, never on mac_valid.
    always_comb begin
        mac_ready_c = (state == S_RECV) && !full;
        busy        = (state != S_IDLE);
    end

    assign push = bus.mac_valid && mac_ready_c;
    assign pop  = bus.out_ready && !empty;

    // The engine's sum is a live wire, so it is captured on the handshake edge itself.
    always_ff @(posedge clk) begin
        if (!nrst)     seq <= '0;
        else if (push) seq <= seq + TAG_W'(1);
    end

    result_fifo #(
        .WIDTH (OUT_W + TAG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .pop   (pop),
        .wdata ({extend(bus.mac_sum, signed_res), seq}),
        .rdata (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign bus.mac_ready = mac_ready_c;
    assign bus.out_valid = !empty;
    assign bus.out_data  = head[OUT_W+TAG_W-1:TAG_W];
    assign bus.out_tag   = head[TAG_W-1:0];

endmodule

// File: tb/tb_mac_result_collector.sv
// Bench for mac_result_collector: vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_mac_result_collector;
    import mac_result_collector_pkg::*;

    logic       clk;
    logic       nrst;
    logic       en;
    logic       signed_res;
    logic [2:0] level;
    logic       busy;

    mac_result_collector_if #(.SUM_W(20), .OUT_W(32), .TAG_W(8)) bus ();

    mac_result_collector #(.SUM_W(20), .OUT_W(32), .DEPTH(4), .TAG_W(8)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .en         (en),
        .signed_res (signed_res),
        .bus        (bus.slave),
        .level      (level),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: queue of {data, tag}, sequence counter, run phase 0 idle/1 recv/2 drain
    logic [39:0] mq[$];
    int          mseq  = 0;
    int          mphase = 0;

    typedef struct {
        bit          en, sg, v;
        logic [19:0] sum;
        bit          ordy;
        bit          e_rdy, e_ov;
        int          e_lvl;
        bit          e_busy;
        logic [31:0] e_data;
        logic [7:0]  e_tag;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(bit e, bit sg, bit v, logic [19:0] sum, bit ordy,
                                bit rdy, bit ov, int lvl, bit bsy, logic [31:0] d, logic [7:0] t);
        vec_t r;
        r.en = e; r.sg = sg; r.v = v; r.sum = sum; r.ordy = ordy;
        r.e_rdy = rdy; r.e_ov = ov; r.e_lvl = lvl; r.e_busy = bsy; r.e_data = d; r.e_tag = t;
        return r;
    endfunction

    function automatic logic [31:0] ext_m(logic [19:0] s, bit sg);
        longint v;
        v = longint'(s);
        if (sg && v >= 524288) v = v - 1048576;
        return v[31:0];
    endfunction

    task automatic chk(string name, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock: the model consumes the inputs as they stand before the edge.
    task automatic cycle();
        bit rdy_m, ov_m, pu, po;
        int old_n;
        logic [39:0] ent;
        old_n = mq.size();
        rdy_m = (mphase == 1) && (old_n < 4);
        ov_m  = (old_n != 0);
        pu    = bus.mac_valid && rdy_m;
        po    = ov_m && bus.out_ready;
        ent   = {ext_m(bus.mac_sum, signed_res), mseq[7:0]};
        @(posedge clk);
        if (!nrst) begin
            mq.delete();
            mseq   = 0;
            mphase = 0;
        end else begin
            if (po) void'(mq.pop_front());
            if (pu) begin
                mq.push_back(ent);
                mseq = (mseq + 1) % 256;
            end
            case (mphase)
                0: if (en) mphase = 1;
                1: if (!en) mphase = 2;
                default: begin
                    if (en)              mphase = 1;
                    else if (old_n == 0) mphase = 0;
                end
            endcase
        end
        #1;
    endtask

    task automatic check_model(string tag);
        chk({tag, ".mac_ready"}, bus.mac_ready, (mphase == 1) && (mq.size() < 4));
        chk({tag, ".out_valid"}, bus.out_valid, mq.size() != 0);
        chk({tag, ".level"}, level, mq.size());
        chk({tag, ".busy"}, busy, mphase != 0);
        if (mq.size() != 0) begin
            chk({tag, ".out_data"}, bus.out_data, mq[0][39:8]);
            chk({tag, ".out_tag"}, bus.out_tag, mq[0][7:0]);
        end
    endtask

    task automatic set_in(bit e, bit sg, bit v, logic [19:0] sum, bit ordy);
        en = e; signed_res = sg; bus.mac_valid = v; bus.mac_sum = sum; bus.out_ready = ordy;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        set_in(1, 0, 1, 20'h12345, 0);
        cycle();
        cycle();
        nrst = 1'b1;
        set_in(0, 0, 0, 20'h0, 0);
    endtask

    initial begin
        logic [39:0] got[$];
        int          errs;
        int          exp_tag;
        bit          saw_wrap;
        bit          acc5;

        nrst = 1'b1;
        set_in(0, 0, 0, 20'h0, 0);
        #2;

        // Reset with mac_valid held high
        do_reset();
        chk("reset.mac_ready", bus.mac_ready, 0);
        chk("reset.out_valid", bus.out_valid, 0);
        chk("reset.level", level, 0);
        chk("reset.busy", busy, 0);
        chk("reset.out_data", bus.out_data, 0);
        chk("reset.out_tag", bus.out_tag, 0);

        // Vector table, applied from the reset state
        tbl[0]  = mk(1, 0, 0, 20'h0,     0, 1, 0, 0, 1, 32'h0,        8'd0);
        tbl[1]  = mk(1, 1, 1, 20'hFFFFE, 0, 1, 1, 1, 1, 32'hFFFFFFFE, 8'd0);
        tbl[2]  = mk(1, 0, 1, 20'hFFFFE, 1, 1, 1, 1, 1, 32'h000FFFFE, 8'd1);
        tbl[3]  = mk(1, 0, 0, 20'h0,     1, 1, 0, 0, 1, 32'h0,        8'd0);
        tbl[4]  = mk(1, 1, 1, 20'h7FFFF, 0, 1, 1, 1, 1, 32'h0007FFFF, 8'd2);
        tbl[5]  = mk(1, 1, 1, 20'h80000, 0, 1, 1, 2, 1, 32'h0007FFFF, 8'd2);
        tbl[6]  = mk(1, 0, 0, 20'h0,     1, 1, 1, 1, 1, 32'hFFF80000, 8'd3);
        tbl[7]  = mk(0, 0, 0, 20'h0,     0, 0, 1, 1, 1, 32'hFFF80000, 8'd3);
        tbl[8]  = mk(0, 0, 1, 20'h55555, 0, 0, 1, 1, 1, 32'hFFF80000, 8'd3);
        tbl[9]  = mk(0, 0, 0, 20'h0,     1, 0, 0, 0, 1, 32'h0,        8'd0);
        tbl[10] = mk(0, 0, 0, 20'h0,     0, 0, 0, 0, 0, 32'h0,        8'd0);
        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].en, tbl[i].sg, tbl[i].v, tbl[i].sum, tbl[i].ordy);
            cycle();
            chk($sformatf("vec%0d.mac_ready", i), bus.mac_ready, tbl[i].e_rdy);
            chk($sformatf("vec%0d.out_valid", i), bus.out_valid, tbl[i].e_ov);
            chk($sformatf("vec%0d.level", i), level, tbl[i].e_lvl);
            chk($sformatf("vec%0d.busy", i), busy, tbl[i].e_busy);
            if (tbl[i].e_ov) begin
                chk($sformatf("vec%0d.out_data", i), bus.out_data, tbl[i].e_data);
                chk($sformatf("vec%0d.out_tag", i), bus.out_tag, tbl[i].e_tag);
            end
        end

        // Fill to full, engine holds sum 5, then drain in order with no loss
        do_reset();
        set_in(1, 0, 0, 20'h0, 0);
        cycle();
        for (int k = 1; k <= 4; k++) begin
            set_in(1, 0, 1, 20'(k), 0);
            cycle();
        end
        set_in(1, 0, 1, 20'd5, 0);
        cycle();
        chk("fill.level", level, 4);
        chk("fill.mac_ready", bus.mac_ready, 0);
        bus.out_ready = 1'b1;
        acc5 = 0;
        got.delete();
        for (int n = 0; n < 20; n++) begin
            if (bus.out_valid) got.push_back({bus.out_data, bus.out_tag});
            acc5 = bus.mac_valid && bus.mac_ready;
            cycle();
            if (acc5) bus.mac_valid = 1'b0;
            if (got.size() == 5 && level == 0) break;
        end
        chk("fill.pop_count", got.size(), 5);
        for (int i = 0; i < got.size() && i < 5; i++) begin
            chk($sformatf("fill.data%0d", i), got[i][39:8], i + 1);
            chk($sformatf("fill.tag%0d", i), got[i][7:0], i);
        end

        // Simultaneous push and pop at level 2
        do_reset();
        set_in(1, 0, 0, 20'h0, 0);
        cycle();
        set_in(1, 0, 1, 20'd10, 0); cycle();
        set_in(1, 0, 1, 20'd11, 0); cycle();
        chk("simul.pre_level", level, 2);
        chk("simul.pre_tag", bus.out_tag, 0);
        set_in(1, 0, 1, 20'd12, 1);
        cycle();
        chk("simul.level", level, 2);
        chk("simul.tag", bus.out_tag, 1);
        chk("simul.data", bus.out_data, 11);

        // Drain after en drops with three entries queued
        do_reset();
        set_in(1, 0, 0, 20'h0, 0);
        cycle();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 1, 1, 20'(k + 100), 0);
            cycle();
        end
        set_in(0, 0, 0, 20'h0, 0);
        cycle();
        chk("drain.busy", busy, 1);
        chk("drain.mac_ready", bus.mac_ready, 0);
        chk("drain.level", level, 3);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        chk("drain.empty_level", level, 0);
        chk("drain.empty_valid", bus.out_valid, 0);
        chk("drain.busy_last_pop", busy, 1);
        cycle();
        chk("drain.idle_busy", busy, 0);

        // Tag wrap over 260 pushes, then reset with results queued
        do_reset();
        set_in(1, 0, 0, 20'h0, 0);
        cycle();
        errs = 0;
        exp_tag = 0;
        saw_wrap = 0;
        for (int n = 0; n < 260; n++) begin
            set_in(1, 0, 1, 20'($urandom), 1);
            if (bus.out_valid) begin
                if (bus.out_tag != 8'(exp_tag)) errs++;
                if (exp_tag == 256) saw_wrap = 1;
                exp_tag++;
            end
            cycle();
        end
        chk("wrap.tag_errors", errs, 0);
        chk("wrap.seen", saw_wrap, 1);
        set_in(1, 0, 1, 20'd7, 0);
        for (int k = 0; k < 3; k++) cycle();
        chk("wrap.level_full", level, 4);
        nrst = 1'b0;
        cycle();
        nrst = 1'b1;
        chk("midrst.level", level, 0);
        chk("midrst.out_valid", bus.out_valid, 0);
        set_in(1, 0, 0, 20'h0, 0);
        cycle();
        set_in(1, 0, 1, 20'd9, 0);
        cycle();
        chk("midrst.out_valid2", bus.out_valid, 1);
        chk("midrst.tag", bus.out_tag, 0);
        chk("midrst.data", bus.out_data, 9);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            nrst = ($urandom_range(0, 299) != 0);
            set_in($urandom_range(0, 9) != 0, $urandom_range(0, 1), $urandom_range(0, 2) != 0,
                   20'($urandom), $urandom_range(0, 2) != 0);
            cycle();
            check_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
